// File: rtl/compressed_token_fetcher_pkg.sv
// Shared types and constants for the compressed token fetcher.
package compressed_token_fetcher_pkg;
  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, PRESENT, ADVANCE, DONE} state_t;
  localparam int TOKEN_BYTES = 2;
  localparam int RUN_W = 15;
  localparam logic [RUN_W-1:0] EOS_RUN = '0;
endpackage

// File: rtl/compressed_token_fetcher_run_cursor.sv
// Bit-granular output cursor: 35-bit position split into byte index and MSB-first bit index.
module run_cursor
  import compressed_token_fetcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [31:0]      load_byte_i,
  input  logic             adv_i,
  input  logic [RUN_W-1:0] run_i,
  output logic [31:0]      byte_idx_o,
  output logic [2:0]       bit_idx_o
);
  logic [34:0] p_q;

  // The byte part wraps naturally by truncating to 35 bits.
  always_ff @(posedge clk) begin
    if (rst)         p_q <= '0;
    else if (load_i) p_q <= {load_byte_i, 3'b000};
    else if (adv_i)  p_q <= p_q + 35'(run_i);
  end

  assign byte_idx_o = p_q[34:3];
  assign bit_idx_o  = 3'd7 - p_q[2:0];
endmodule

// File: rtl/compressed_token_fetcher.sv
// Fetches 2-byte run tokens from RAM and presents them with the running output cursor.
module compressed_token_fetcher
  import compressed_token_fetcher_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MAX_TOKENS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       out_byte_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        in1,
  output logic [7:0]        in2,
  output logic [31:0]       byteIndx,
  output logic [2:0]        bitIndx,
  output logic              work,
  input  logic              tok_ready,
  output logic              busy,
  output logic              done,
  output logic              limit_hit
);
  localparam int CNT_W = $clog2(MAX_TOKENS + 1);

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q, mem_addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        in1_q, in2_q;
  logic              mem_rd_q, work_q, busy_q, done_q, limit_q;
  logic              load, adv;
  logic [RUN_W-1:0]  run;

  assign load = (state_q == IDLE) && start;
  assign adv  = (state_q == PRESENT) && tok_ready;
  assign run  = {in1_q[6:0], in2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mem_addr_q <= '0;
      count_q    <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      mem_rd_q   <= 1'b0;
      work_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ptr_q      <= base_addr;
            count_q    <= '0;
            limit_q    <= 1'b0;
            busy_q     <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= base_addr;
            state_q    <= RD0;
          end
        end
        RD0: begin
          mem_addr_q <= ptr_q + 1'b1;
          state_q    <= RD1;
        end
        RD1: begin
          in1_q    <= mem_rdata;
          mem_rd_q <= 1'b0;
          state_q  <= CAP;
        end
        CAP: begin
          in2_q <= mem_rdata;
          // Run is judged on the byte arriving now, before it lands in in2_q.
          if ({in1_q[6:0], mem_rdata} == EOS_RUN) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            work_q  <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (tok_ready) begin
            work_q  <= 1'b0;
            ptr_q   <= ptr_q + ADDR_W'(TOKEN_BYTES);
            count_q <= count_q + 1'b1;
            state_q <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (count_q == CNT_W'(MAX_TOKENS)) begin
            limit_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ptr_q;
            state_q    <= RD0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  run_cursor u_cursor (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_byte_i(out_byte_base),
    .adv_i      (adv),
    .run_i      (run),
    .byte_idx_o (byteIndx),
    .bit_idx_o  (bitIndx)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign in1       = in1_q;
  assign in2       = in2_q;
  assign work      = work_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign limit_hit = limit_q;
endmodule

// File: tb/tb_compressed_token_fetcher.sv
// Directed bench for compressed_token_fetcher; a second instance runs with MAX_TOKENS=2.
module tb_compressed_token_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [15:0] base_addr = '0;
  logic [31:0] out_byte_base = '0;
  logic        tok_ready = 1'b0, tok_ready2 = 1'b0;
  logic [15:0] mem_addr, mem_addr2;
  logic        mem_rd, mem_rd2;
  logic [7:0]  rdata = '0, rdata2 = '0;
  logic [7:0]  in1, in2, in1_2, in2_2;
  logic [31:0] byteIndx, byteIndx2;
  logic [2:0]  bitIndx, bitIndx2;
  logic        work, busy, done, limit_hit;
  logic        work2, busy2, done2, limit_hit2;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] rd_log2[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd)  begin rdata  <= mem[mem_addr];  rd_log.push_back(mem_addr);   end
    if (mem_rd2) begin rdata2 <= mem[mem_addr2]; rd_log2.push_back(mem_addr2); end
  end

  compressed_token_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .out_byte_base(out_byte_base), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(rdata), .in1(in1), .in2(in2), .byteIndx(byteIndx),
    .bitIndx(bitIndx), .work(work), .tok_ready(tok_ready), .busy(busy),
    .done(done), .limit_hit(limit_hit)
  );

  compressed_token_fetcher #(.ADDR_W(16), .MAX_TOKENS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base_addr),
    .out_byte_base(out_byte_base), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
    .mem_rdata(rdata2), .in1(in1_2), .in2(in2_2), .byteIndx(byteIndx2),
    .bitIndx(bitIndx2), .work(work2), .tok_ready(tok_ready2), .busy(busy2),
    .done(done2), .limit_hit(limit_hit2)
  );

  task automatic pulse_start(input logic [15:0] b, input logic [31:0] o);
    @(negedge clk); start = 1'b1; base_addr = b; out_byte_base = o;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_work(input int lim, output bit ok);
    int n = 0;
    while (!work && n < lim) begin @(negedge clk); n++; end
    ok = work;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    ok = done;
  endtask

  task automatic handshake;
    tok_ready = 1'b1;
    @(negedge clk);
    tok_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({work, mem_rd, busy, done, limit_hit} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {work, mem_rd, busy, done, limit_hit});
    end
    total++;
    if ({in1, in2, mem_addr, byteIndx, bitIndx} !== {8'h0, 8'h0, 16'h0, 32'h0, 3'd7}) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h/%0d exp=0/0/0/0/7", in1, in2, mem_addr, byteIndx, bitIndx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    mem[16'h100] = 8'h80; mem[16'h101] = 8'h05;
    mem[16'h102] = 8'h00; mem[16'h103] = 8'h0B;
    mem[16'h104] = 8'h00; mem[16'h105] = 8'h00;
    pulse_start(16'h100, 32'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    repeat (3) @(negedge clk);
    total++;
    if (work !== 1'b1) begin bad++; $display("FAIL basic_latency work=%b exp=1 four cycles after start", work); end
    total++;
    if ({in1, in2, byteIndx, bitIndx} !== {8'h80, 8'h05, 32'd0, 3'd7}) begin
      bad++; $display("FAIL basic_tok0 got=%h/%h/%0d/%0d exp=80/05/0/7", in1, in2, byteIndx, bitIndx);
    end
    handshake();
    wait_work(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_tok1_timeout work=%b exp=1", work); end
    total++;
    if ({in1, in2, byteIndx, bitIndx} !== {8'h00, 8'h0B, 32'd0, 3'd2}) begin
      bad++; $display("FAIL basic_tok1 got=%h/%h/%0d/%0d exp=00/0B/0/2", in1, in2, byteIndx, bitIndx);
    end
    handshake();
    wait_done(12, ok);
    total++;
    if (!ok || busy !== 1'b0 || limit_hit !== 1'b0) begin
      bad++; $display("FAIL basic_done got done=%b busy=%b lim=%b exp=1/0/0", done, busy, limit_hit);
    end
    total++;
    if (byteIndx !== 32'd2 || bitIndx !== 3'd7) begin
      bad++; $display("FAIL basic_final got=%0d/%0d exp=2/7", byteIndx, bitIndx);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || byteIndx !== 32'd2 || bitIndx !== 3'd7) begin
      bad++; $display("FAIL basic_after_done got done=%b %0d/%0d exp=0 2/7", done, byteIndx, bitIndx);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int n0, errs;
    mem[16'h200] = 8'h01; mem[16'h201] = 8'h00;
    mem[16'h202] = 8'h00; mem[16'h203] = 8'h00;
    pulse_start(16'h200, 32'd5);
    wait_work(10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_timeout work=%b exp=1", work); end
    n0 = rd_log.size();
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if ({work, mem_rd, in1, in2, byteIndx, bitIndx} !== {1'b1, 1'b0, 8'h01, 8'h00, 32'd5, 3'd7}) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0 || rd_log.size() != n0) begin
      bad++; $display("FAIL bp_stable got unstable_cycles=%0d reads=%0d exp=0/0", errs, rd_log.size() - n0);
    end
    handshake();
    wait_done(12, ok);
    total++;
    if (!ok || byteIndx !== 32'd37 || bitIndx !== 3'd7) begin
      bad++; $display("FAIL bp_final got done=%b %0d/%0d exp=1 37/7", done, byteIndx, bitIndx);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h03;
    mem[16'h0001] = 8'h00; mem[16'h0002] = 8'h00;
    @(negedge clk);
    rd_log.delete();
    pulse_start(16'hFFFF, 32'd0);
    wait_work(10, ok);
    total++;
    if (!ok || rd_log.size() != 2 || rd_log[0] !== 16'hFFFF || rd_log[1] !== 16'h0000) begin
      bad++; $display("FAIL wrap_first_reads got n=%0d %h %h exp=2 FFFF 0000", rd_log.size(), rd_log[0], rd_log[1]);
    end
    total++;
    if (in2 !== 8'h03) begin bad++; $display("FAIL wrap_in2 got=%h exp=03", in2); end
    handshake();
    wait_done(12, ok);
    total++;
    if (!ok || rd_log.size() != 4 || rd_log[2] !== 16'h0001 || rd_log[3] !== 16'h0002) begin
      bad++; $display("FAIL wrap_next_reads got n=%0d %h %h exp=4 0001 0002", rd_log.size(), rd_log[2], rd_log[3]);
    end
    total++;
    if (byteIndx !== 32'd0 || bitIndx !== 3'd4) begin
      bad++; $display("FAIL wrap_final got=%0d/%0d exp=0/4", byteIndx, bitIndx);
    end
  endtask

  task automatic test_max_run;
    bit ok;
    mem[16'h300] = 8'h7F; mem[16'h301] = 8'hFF;
    mem[16'h302] = 8'h00; mem[16'h303] = 8'h00;
    mem[16'h310] = 8'h00; mem[16'h311] = 8'h08;
    mem[16'h312] = 8'h00; mem[16'h313] = 8'h00;
    @(negedge clk);
    pulse_start(16'h300, 32'd0);
    wait_work(10, ok);
    handshake();
    wait_done(12, ok);
    total++;
    if (!ok || byteIndx !== 32'd4095 || bitIndx !== 3'd0) begin
      bad++; $display("FAIL maxrun_final got done=%b %0d/%0d exp=1 4095/0", done, byteIndx, bitIndx);
    end
    @(negedge clk);
    pulse_start(16'h310, 32'hFFFF_FFFF);
    wait_work(10, ok);
    total++;
    if (!ok || byteIndx !== 32'hFFFF_FFFF || bitIndx !== 3'd7) begin
      bad++; $display("FAIL maxbase_present got work=%b %h/%0d exp=1 FFFFFFFF/7", work, byteIndx, bitIndx);
    end
    handshake();
    wait_done(12, ok);
    total++;
    if (!ok || byteIndx !== 32'd0 || bitIndx !== 3'd7) begin
      bad++; $display("FAIL maxbase_wrap got done=%b %h/%0d exp=1 0/7", done, byteIndx, bitIndx);
    end
  endtask

  task automatic test_limit;
    int n_hs = 0;
    for (int a = 0; a < 6; a += 2) begin
      mem[16'h400 + a] = 8'h00; mem[16'h401 + a] = 8'h01;
    end
    mem[16'h406] = 8'h00; mem[16'h407] = 8'h00;
    @(negedge clk);
    rd_log2.delete();
    start2 = 1'b1; base_addr = 16'h400; out_byte_base = 32'd0;
    @(negedge clk); start2 = 1'b0;
    for (int c = 0; c < 60 && !done2; c++) begin
      tok_ready2 = work2;
      if (work2) n_hs++;
      @(negedge clk);
    end
    tok_ready2 = 1'b0;
    total++;
    if (done2 !== 1'b1 || limit_hit2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++; $display("FAIL limit_done got done=%b lim=%b busy=%b exp=1/1/0", done2, limit_hit2, busy2);
    end
    total++;
    if (n_hs != 2 || rd_log2.size() != 4) begin
      bad++; $display("FAIL limit_count got hs=%0d reads=%0d exp=2/4", n_hs, rd_log2.size());
    end
    total++;
    if (byteIndx2 !== 32'd0 || bitIndx2 !== 3'd5) begin
      bad++; $display("FAIL limit_cursor got=%0d/%0d exp=0/5", byteIndx2, bitIndx2);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(negedge clk);
    pulse_start(16'h100, 32'd0);
    wait_work(10, ok);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (!ok || work !== 1'b1 || busy !== 1'b1 || mem_rd !== 1'b0 || in1 !== 8'h80) begin
      bad++; $display("FAIL busy_start_ignored got work=%b busy=%b rd=%b in1=%h exp=1/1/0/80", work, busy, mem_rd, in1);
    end
    rst = 1'b1; tok_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({work, mem_rd, busy, done, in1, in2, mem_addr, byteIndx, bitIndx} !==
        {4'b0, 8'h0, 8'h0, 16'h0, 32'h0, 3'd7}) begin
      bad++; $display("FAIL reset_mid got work=%b busy=%b in1=%h addr=%h %0d/%0d exp=0/0/0/0 0/7",
                      work, busy, in1, mem_addr, byteIndx, bitIndx);
    end
    rst = 1'b0; tok_ready = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (work !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || byteIndx !== 32'd0) begin
      bad++; $display("FAIL reset_mid_quiet got work=%b busy=%b rd=%b byte=%0d exp=0/0/0/0", work, busy, mem_rd, byteIndx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_max_run();
    test_limit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/compressed_token_fetcher.md
COMPRESSED_TOKEN_FETCHER -- requirements
Module: compressed_token_fetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 SHALL have parameter MAX_TOKENS, default 4096, token limit per stream.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a stream.
REQ-007 SHALL have port base_addr  in  ADDR_W  RAM address of the first compressed byte.
REQ-008 SHALL have port out_byte_base  in  32  first decompressed byte index; start bit is 7.
REQ-009 SHALL have port mem_addr  out  ADDR_W  RAM read address.
REQ-010 SHALL have port mem_rd  out  1  RAM read strobe.
REQ-011 SHALL have port mem_rdata  in  8  RAM data; valid exactly 1 cycle after mem_rd.
REQ-012 SHALL have port in1  out  8  token byte 0: bit7 is the run value, [6:0] is run length high.
REQ-013 SHALL have port in2  out  8  token byte 1: run length low.
REQ-014 SHALL have port byteIndx  out  32  cursor byte where the presented token starts.
REQ-015 SHALL have port bitIndx  out  3  cursor bit; 7 is the MSB, the first bit written.
REQ-016 SHALL have port work  out  1  token valid to the decompress handler.
REQ-017 SHALL have port tok_ready  in  1  handler accepts the token.
REQ-018 SHALL have port busy, done, limit_hit  out  1 each  status flags.

Function
REQ-019 SHALL use FSM states IDLE, RD0, RD1, CAP, PRESENT, ADVANCE, DONE.
REQ-020 IDLE: on start, SHALL latch ptr=base_addr and cursor p=out_byte_base*8; go to RD0; busy=1 from the next cycle.
REQ-021 RD0: mem_rd=1, mem_addr=ptr.
REQ-022 RD1: capture in1 from mem_rdata; mem_rd=1, mem_addr=ptr+1 modulo 2^ADDR_W.
REQ-023 CAP: capture in2; run={in1[6:0],in2} (15 bit); run==0 means end-of-stream and goes to DONE; otherwise go to PRESENT.
REQ-024 PRESENT: work=1; in1, in2, byteIndx=p[34:3] and bitIndx=7-p[2:0] SHALL hold stable until work&&tok_ready.
REQ-025 On handshake: go to ADVANCE; p+=run, 35-bit, byte part wraps modulo 2^32; ptr+=2 modulo 2^ADDR_W; token count +1.
REQ-026 ADVANCE: work=0; if count==MAX_TOKENS, go to DONE with limit_hit=1, else go to RD0.
REQ-027 Latency: start to first work SHALL be 4 cycles; handshake to next work SHALL be 4 cycles.
REQ-028 DONE: done=1 for exactly one cycle with busy=0 in the same cycle; then IDLE. byteIndx/bitIndx SHALL show the final cursor until the next start.
REQ-029 start while busy SHALL be ignored; tok_ready outside PRESENT SHALL be ignored.
REQ-030 mem_rd SHALL be 0 in every state except RD0/RD1.

Reset
REQ-031 While rst=1 at a clock edge: state=IDLE; work, mem_rd, busy, done, limit_hit=0; in1, in2, mem_addr, byteIndx=0; bitIndx=7; count=0.
REQ-032 Reset SHALL take priority over start and over tok_ready, including mid-PRESENT; no cursor advance follows.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, TOKEN_BYTES=2, RUN_W=15 and the EOS run code 0.
REQ-034 One sub-module, run_cursor, SHALL hold the p register, the add, and the byteIndx/bitIndx split; the FSM is the top.

Verification
REQ-035 Basic stream: out_byte_base=0, tokens 80/05, 00/0B, then 00/00 -> presented cursors (0,7), then (0,2), then done with final (2,7); limit_hit=0.
REQ-036 Backpressure: hold tok_ready=0 for 10 cycles in PRESENT -> work, in1, in2 and cursor stable; no mem_rd toggles.
REQ-037 Address wrap: base_addr=0xFFFF -> second read at 0x0000; next token read at 0x0001.
REQ-038 Max run: out_byte_base=0, token 7F/FF -> after it the cursor is (4095,0); out_byte_base=0xFFFFFFFF with run 8 -> (0,7).
REQ-039 Limit: MAX_TOKENS=2 with 3 nonzero tokens -> 2 handshakes, then done and limit_hit=1; third token never read.
REQ-040 Reset mid-PRESENT and a start pulse during busy -> outputs return to reset values next cycle; the ignored start causes no restart.
